date_to_doy: RTL and testbench
==============================

# date_to_doy

Sequential converter from a calendar date (month, BCD day) to day-of-year in three BCD digits, with start/done handshake. It is the inverse of the day-of-year to month/day translator and feeds the calendar display path. It validates the date against month lengths, with February length selected by `leap`. Full year is covered: results 001–365, or 366 in a leap year.

## Interface
- No parameters; all widths fixed.
- `clock` in 1: single system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `month` in 4: binary month, valid range 1–12.
- `day2` in 4: BCD tens digit of day.
- `day1` in 4: BCD ones digit of day.
- `leap` in 1: 1 = leap year (February has 29 days).
- `busy` out 1: high in CHECK, ACCUM, CONVERT.
- `done` out 1: one-cycle pulse in DONE.
- `err` out 1: invalid date flag for the last request; valid while `done` is high and held after.
- `hund` out 4: BCD hundreds digit of day-of-year.
- `tens` out 4: BCD tens digit.
- `ones` out 4: BCD ones digit.

## Operation
- FSM states: IDLE, CHECK, ACCUM, CONVERT, DONE.
- IDLE, `start`=1:
  - Capture `month`, `day2`, `day1` and `leap` into registers.
  - Go to CHECK.
  - Inputs may change afterwards without effect.
- CHECK rejects the date if any of these hold: month=0; month>12; day2>9; day1>9; day value (10·day2+day1) =0; day value > month length.
  - On rejection: set `err`=1, load `hund`/`tens`/`ones`=0, go to DONE.
- CHECK, valid date: `acc` (9-bit) = day value, `err`=0. Go to ACCUM if month>1, else CONVERT.
- ACCUM: each cycle adds the length of month k, for k = 1 … month−1, to `acc`; then go to CONVERT.
- Month lengths: 31, 28+leap, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31.
- CONVERT: 9-bit binary-to-BCD by double-dabble, exactly 9 shift cycles.
  - Result bounded to ≤366, so the hundreds digit is ≤3.
  - `hund`/`tens`/`ones` load on the final shift edge, together with the transition to DONE.
- DONE: `done`=1 for one cycle, then return to IDLE unconditionally.
- `start` is ignored in every state except IDLE, including DONE.
- Outputs `hund`/`tens`/`ones`/`err` hold their values until the next request completes.

## Timing
- Let E0 be the edge that samples `start`=1 in IDLE.
- Valid date: `done` high in the cycle after edge E0+month+9.
  - January: E0+10.
  - December: E0+21.
- Invalid date: `done` high in the cycle after E0+1.
- `busy` rises after E0 and falls on the edge that enters DONE.
- Back-to-back operation: `start` held high is accepted again on the edge following DONE, i.e. on re-entry to IDLE.
- Reset values: state IDLE; `busy`=0, `done`=0, `err`=0, `hund`=`tens`=`ones`=0; internal accumulators 0.
- Reset asserted mid-operation: immediate abort to IDLE with the reset values above; no `done` pulse is produced.

## Structure
- Shared calendar package holds:
  - FSM state enum.
  - Month-length constant table (non-leap).
  - MAX_DOY=366.
  - BCD digit width constant.
- Sub-module `bin2bcd_dd`: sequential 9-bit double-dabble engine.
  - Interface: load, 9 shift cycles, three BCD digits out.
  - Driven by the CONVERT state.
- ACCUM month counter and adder stay in the top module.

## Test plan
- month=1, day=0/1, leap=0 -> `hund`/`tens`/`ones`=0/0/1, `err`=0, `done` exactly after E0+10, `busy` high 10 cycles.
- month=3, day=0/1 -> 0/6/0 with leap=0; 0/6/1 with leap=1.
- month=12, day=3/1, leap=1 -> 3/6/6, `done` after E0+21; repeat with leap=0 -> 3/6/5.
- Invalid inputs -> `err`=1, digits 0/0/0, `done` after E0+1:
  - month=2, day=3/0, leap=1.
  - month=13.
  - day1=4'hA.
  - day 0/0.
- Deassert `reset_n` mid-ACCUM of a month=9 request:
  - Immediately all outputs 0, `busy`=0, no `done` pulse.
  - New request month=9, day=1/5 completes with 2/5/8 (leap=0).
- Pulse `start` with a different date while busy and during DONE -> ignored; results reflect the first request only.

Source files
------------

// File: rtl/date_to_doy_pkg.sv
// Shared calendar definitions for the date to day-of-year converter.
//   state_t   : converter FSM states
//   MONTH_LEN : non-leap month lengths, index 0 = January
//   MAX_DOY   : largest day-of-year value produced
//   BCD_W     : width of one BCD digit
//   month_len : length of a month (1-12), February extended by leap; 0 otherwise
package date_to_doy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ACCUM,
    ST_CONVERT,
    ST_DONE
  } state_t;

  localparam int unsigned BCD_W   = 4;
  localparam int unsigned MAX_DOY = 366;

  localparam logic [4:0] MONTH_LEN [12] = '{
    5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
    5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
  };

  function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
    logic [4:0] len;
    len = '0;
    if (m != 4'd0 && m <= 4'd12) begin
      len = MONTH_LEN[m - 4'd1];
      if (m == 4'd2) len = len + {4'd0, leap};
    end
    return len;
  endfunction

endpackage

// File: rtl/date_to_doy_bin2bcd_dd.sv
// Sequential 9-bit binary to 3-digit BCD converter (double-dabble).
//   clock, reset_n : system clock, async active-low reset
//   load, bin      : load a new binary value and clear the BCD digits
//   shift          : perform one adjust-and-shift step
//   last           : the current shift is the ninth (final) step
//   hund/tens/ones : BCD digits as they will be after the current shift,
//                    so the caller can capture the result on the final edge
module bin2bcd_dd
  import date_to_doy_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [8:0]       bin,
  output logic             last,
  output logic [BCD_W-1:0] hund,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones
);

  logic [8:0]         sr;
  logic [3*BCD_W-1:0] bcd;
  logic [3*BCD_W-1:0] bcd_next;
  logic [3:0]         cnt;
  logic [BCD_W-1:0]   a0, a1, a2;

  always_comb begin
    a0 = bcd[BCD_W-1:0];
    a1 = bcd[2*BCD_W-1:BCD_W];
    a2 = bcd[3*BCD_W-1:2*BCD_W];
    if (a0 >= 4'd5) a0 = a0 + 4'd3;
    if (a1 >= 4'd5) a1 = a1 + 4'd3;
    if (a2 >= 4'd5) a2 = a2 + 4'd3;
    bcd_next = {a2[BCD_W-2:0], a1, a0, sr[8]};
  end

  assign hund = bcd_next[3*BCD_W-1:2*BCD_W];
  assign tens = bcd_next[2*BCD_W-1:BCD_W];
  assign ones = bcd_next[BCD_W-1:0];
  assign last = (cnt == 4'd8);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sr  <= '0;
      bcd <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= bin;
      bcd <= '0;
      cnt <= '0;
    end else if (shift) begin
      sr  <= {sr[7:0], 1'b0};
      bcd <= bcd_next;
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/date_to_doy.sv
// Converts a calendar date (binary month, BCD day) to a 3-digit BCD
// day-of-year with a start/done handshake.
//   clock, reset_n     : system clock, async active-low reset
//   start              : request, sampled only in IDLE
//   month, day2, day1  : binary month, BCD day tens/ones
//   leap               : February has 29 days
//   busy               : conversion in progress (CHECK/ACCUM/CONVERT)
//   done               : one-cycle completion pulse
//   err                : last request was an invalid date
//   hund, tens, ones   : BCD day-of-year (000 on error)
module date_to_doy
  import date_to_doy_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       month,
  input  logic [3:0]       day2,
  input  logic [3:0]       day1,
  input  logic             leap,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [BCD_W-1:0] hund,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones
);

  state_t     state;
  logic [3:0] month_r, day2_r, day1_r;
  logic       leap_r;
  logic [8:0] acc;
  logic [3:0] mcnt;

  logic [7:0] day_val;
  logic [4:0] cur_len, acc_len;
  logic       date_bad;
  logic [8:0] acc_sum;
  logic       dd_load, dd_shift, dd_last;
  logic [8:0] dd_bin;
  logic [BCD_W-1:0] dd_hund, dd_tens, dd_ones;

  always_comb begin
    day_val  = 8'(day2_r) * 8'd10 + 8'(day1_r);
    cur_len  = month_len(month_r, leap_r);
    acc_len  = month_len(mcnt, leap_r);
    date_bad = (month_r == 4'd0) || (month_r > 4'd12) ||
               (day2_r > 4'd9) || (day1_r > 4'd9) ||
               (day_val == 8'd0) || (day_val > {3'd0, cur_len});
    acc_sum  = acc + {4'd0, acc_len};
  end

  // The converter is loaded on the edge that enters CONVERT, so it sees the
  // final accumulated value (acc_sum on the last ACCUM cycle) directly.
  always_comb begin
    dd_load  = 1'b0;
    dd_bin   = '0;
    dd_shift = (state == ST_CONVERT);
    if (state == ST_CHECK && !date_bad && month_r == 4'd1) begin
      dd_load = 1'b1;
      dd_bin  = {1'b0, day_val};
    end else if (state == ST_ACCUM && mcnt == month_r - 4'd1) begin
      dd_load = 1'b1;
      dd_bin  = acc_sum;
    end
  end

  bin2bcd_dd u_bin2bcd_dd (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (dd_load),
    .shift   (dd_shift),
    .bin     (dd_bin),
    .last    (dd_last),
    .hund    (dd_hund),
    .tens    (dd_tens),
    .ones    (dd_ones)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      month_r <= '0;
      day2_r  <= '0;
      day1_r  <= '0;
      leap_r  <= 1'b0;
      acc     <= '0;
      mcnt    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      hund    <= '0;
      tens    <= '0;
      ones    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            month_r <= month;
            day2_r  <= day2;
            day1_r  <= day1;
            leap_r  <= leap;
            busy    <= 1'b1;
            state   <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (date_bad) begin
            err   <= 1'b1;
            hund  <= '0;
            tens  <= '0;
            ones  <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            err   <= 1'b0;
            acc   <= {1'b0, day_val};
            mcnt  <= 4'd1;
            state <= (month_r > 4'd1) ? ST_ACCUM : ST_CONVERT;
          end
        end
        ST_ACCUM: begin
          acc  <= acc_sum;
          mcnt <= mcnt + 4'd1;
          if (mcnt == month_r - 4'd1) state <= ST_CONVERT;
        end
        ST_CONVERT: begin
          if (dd_last) begin
            hund  <= dd_hund;
            tens  <= dd_tens;
            ones  <= dd_ones;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_date_to_doy.sv
module tb_date_to_doy;

  typedef struct {
    logic       err;
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    int         lat;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] month = '0, day2 = '0, day1 = '0;
  logic       leap = 1'b0;
  logic       busy, done, err;
  logic [3:0] hund, tens, ones;

  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  date_to_doy dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .month   (month),
    .day2    (day2),
    .day1    (day1),
    .leap    (leap),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .hund    (hund),
    .tens    (tens),
    .ones    (ones)
  );

  function automatic exp_t model(input int m, input int d2, input int d1, input bit lp);
    int ml[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    exp_t e;
    int dv, len, doy;
    dv  = d2 * 10 + d1;
    len = (m >= 1 && m <= 12) ? ml[m-1] + ((m == 2 && lp) ? 1 : 0) : 0;
    if (m < 1 || m > 12 || d2 > 9 || d1 > 9 || dv == 0 || dv > len) begin
      e.err = 1'b1; e.h = 4'd0; e.t = 4'd0; e.o = 4'd0; e.lat = 1;
    end else begin
      doy = dv;
      for (int k = 1; k < m; k++) doy += ml[k-1] + ((k == 2 && lp) ? 1 : 0);
      e.err = 1'b0;
      e.h = 4'(doy / 100);
      e.t = 4'((doy / 10) % 10);
      e.o = 4'(doy % 10);
      e.lat = m + 9;
    end
    return e;
  endfunction

  // Issues one request, scrambles the inputs after capture, waits for done
  // (bounded) and checks result, latency, busy duration and pulse width.
  // disturb: pulse start with another date while busy and during DONE.
  task automatic run_req(input int m, input int d2, input int d1, input bit lp,
                         input bit disturb);
    exp_t e;
    int n, busy_cnt;
    bit seen;
    sb.push_back(model(m, d2, d1, lp));
    @(negedge clock);
    month = 4'(m); day2 = 4'(d2); day1 = 4'(d1); leap = lp; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    month = 4'($urandom_range(0, 15)); day2 = 4'($urandom_range(0, 15));
    day1 = 4'($urandom_range(0, 15)); leap = ~lp;
    n = 0; busy_cnt = 0; seen = 1'b0;
    while (n < 40 && !seen) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) busy_cnt++;
        if (disturb && n == 3) begin start = 1'b1; month = 4'd5; day2 = 4'd2; day1 = 4'd2; end
        if (disturb && n == 4) start = 1'b0;
        @(posedge clock); #1;
        n++;
      end
    end
    e = sb.pop_front();
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL timeout m=%0d: no done within 40 cycles", m);
      return;
    end
    if (disturb) begin start = 1'b1; month = 4'd7; day2 = 4'd0; day1 = 4'd4; end
    vectors++;
    if ({err, hund, tens, ones} !== {e.err, e.h, e.t, e.o}) begin
      miscompares++;
      $display("FAIL result m=%0d d=%0d%0d lp=%0d: got err=%0b %0h%0h%0h want err=%0b %0h%0h%0h",
               m, d2, d1, lp, err, hund, tens, ones, e.err, e.h, e.t, e.o);
    end
    vectors++;
    if (n !== e.lat) begin
      miscompares++;
      $display("FAIL latency m=%0d: got %0d want %0d", m, n, e.lat);
    end
    vectors++;
    if (busy_cnt !== e.lat || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy m=%0d: high %0d cycles (busy@done=%0b) want %0d (0)",
               m, busy_cnt, busy, e.lat);
    end
    @(posedge clock); #1;
    start = 1'b0;
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse m=%0d: done=%0b want 0", m, done);
    end
    if (disturb) begin
      @(posedge clock); #1;
      vectors++;
      if ({busy, err, hund, tens, ones} !== {1'b0, e.err, e.h, e.t, e.o}) begin
        miscompares++;
        $display("FAIL ignore_start: busy=%0b err=%0b %0h%0h%0h want busy=0 err=%0b %0h%0h%0h",
                 busy, err, hund, tens, ones, e.err, e.h, e.t, e.o);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({busy, done, err, hund, tens, ones} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset: busy=%0b done=%0b err=%0b %0h%0h%0h want all 0",
               busy, done, err, hund, tens, ones);
    end
    @(negedge clock); reset_n = 1'b1;
  endtask

  task automatic test_valid();
    run_req(1, 0, 1, 1'b0, 1'b0);
    run_req(3, 0, 1, 1'b0, 1'b0);
    run_req(3, 0, 1, 1'b1, 1'b0);
    run_req(12, 3, 1, 1'b1, 1'b0);
    run_req(12, 3, 1, 1'b0, 1'b0);
    run_req(2, 2, 9, 1'b1, 1'b0);
    run_req(7, 1, 4, 1'b0, 1'b0);
  endtask

  task automatic test_invalid();
    run_req(2, 3, 0, 1'b1, 1'b0);
    run_req(13, 0, 5, 1'b0, 1'b0);
    run_req(4, 1, 10, 1'b0, 1'b0);
    run_req(6, 0, 0, 1'b0, 1'b0);
    run_req(2, 2, 9, 1'b0, 1'b0);
    run_req(0, 1, 1, 1'b0, 1'b0);
    run_req(4, 3, 1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_abort();
    int dcount;
    @(negedge clock);
    month = 4'd9; day2 = 4'd1; day1 = 4'd5; leap = 1'b0; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (4) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, err, hund, tens, ones} !== 15'd0) begin
      miscompares++;
      $display("FAIL abort_reset: busy=%0b done=%0b err=%0b %0h%0h%0h want all 0",
               busy, done, err, hund, tens, ones);
    end
    dcount = 0;
    repeat (3) begin @(posedge clock); #1; if (done) dcount++; end
    @(negedge clock); reset_n = 1'b1;
    repeat (15) begin @(posedge clock); #1; if (done) dcount++; end
    vectors++;
    if (dcount !== 0) begin
      miscompares++;
      $display("FAIL abort_done: %0d done pulses want 0", dcount);
    end
    run_req(9, 1, 5, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_start();
    run_req(1, 2, 5, 1'b0, 1'b1);
    run_req(8, 1, 0, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n;
    int pulses;
    sb.push_back(model(5, 2, 0, 1'b0));
    sb.push_back(model(5, 2, 0, 1'b0));
    @(negedge clock);
    month = 4'd5; day2 = 4'd2; day1 = 4'd0; leap = 1'b0; start = 1'b1;
    n = 0; pulses = 0;
    while (n < 80 && pulses < 2) begin
      @(posedge clock); #1; n++;
      if (done) begin
        e = sb.pop_front();
        pulses++;
        vectors++;
        if ({err, hund, tens, ones} !== {e.err, e.h, e.t, e.o}) begin
          miscompares++;
          $display("FAIL back_to_back #%0d: got err=%0b %0h%0h%0h want err=%0b %0h%0h%0h",
                   pulses, err, hund, tens, ones, e.err, e.h, e.t, e.o);
        end
      end
    end
    start = 1'b0;
    vectors++;
    if (pulses !== 2) begin
      miscompares++;
      $display("FAIL back_to_back_count: %0d done pulses want 2", pulses);
      while (sb.size() > 0) void'(sb.pop_front());
    end
    repeat (25) @(posedge clock);
  endtask

  initial begin
    test_reset();
    test_valid();
    test_invalid();
    test_reset_abort();
    test_ignore_start();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
